// File: rtl/fila_serial_tx.sv
// Drains the FILA byte queue one entry at a time and sends each byte as an
// 8N1 frame on tx_out, with optional idle-high gap bits between frames.
module fila_serial_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DEQ_TIMEOUT  = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic       clock_10KHz,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [3:0] len_in,
  input  logic [7:0] data_in,
  output logic       dequeue_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic [7:0] sent_count_out,
  output logic       timeout_out
);

  // One counter times both bit periods and the inter-frame gap, so it is sized for the longer.
  localparam int GAP_CYCLES = CLKS_PER_BIT * ((GAP_BITS > 0) ? GAP_BITS : 1);
  localparam int CNT_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WAIT_W     = $clog2(DEQ_TIMEOUT);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DEQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  state_t            state;
  logic [3:0]        len_snap;
  logic [7:0]        shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [WAIT_W-1:0] wait_cnt;

  // Outputs are updated on the transition into each state, so tx_out, busy_out and
  // dequeue_out always line up with the state the FSM is currently in.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      len_snap       <= '0;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      wait_cnt       <= '0;
      dequeue_out    <= 1'b0;
      tx_out         <= 1'b1;
      busy_out       <= 1'b0;
      sent_count_out <= '0;
      timeout_out    <= 1'b0;
    end else begin
      dequeue_out <= 1'b0;
      timeout_out <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (enable_in && (len_in != 4'd0)) begin
            state       <= REQ;
            len_snap    <= len_in;
            dequeue_out <= 1'b1;
            busy_out    <= 1'b1;
          end
        end

        REQ: begin
          state    <= WAIT_DATA;
          wait_cnt <= '0;
        end

        // A drop in occupancy is the only proof the dequeue was taken; data_in is valid then.
        WAIT_DATA: begin
          if (len_in < len_snap) begin
            shift_reg <= data_in;
            state     <= START;
            tx_out    <= 1'b0;
            bit_cnt   <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            busy_out    <= 1'b0;
            timeout_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        START: begin
          if (bit_cnt == BIT_LAST) begin
            state     <= DATA;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            tx_out    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_out    <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt        <= '0;
            sent_count_out <= sent_count_out + 8'd1;
            if (GAP_BITS == 0) begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        GAP: begin
          if (bit_cnt == GAP_LAST) begin
            bit_cnt  <= '0;
            state    <= IDLE;
            busy_out <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          tx_out   <= 1'b1;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
